// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access-size codes and size normalisation for the load/store unit
// Contents:
//   lsu_state_t  - controller states IDLE, REQ, WAIT, DONE
//   LSU_SZ_*     - func3 access-size codes (B, H, W, BU, HU)
//   lsu_sz_norm  - maps the unused codes 011/110/111 onto LSU_SZ_W
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_SZ_B  = 3'b000;
    localparam logic [2:0] LSU_SZ_H  = 3'b001;
    localparam logic [2:0] LSU_SZ_W  = 3'b010;
    localparam logic [2:0] LSU_SZ_BU = 3'b100;
    localparam logic [2:0] LSU_SZ_HU = 3'b101;

    function automatic logic [2:0] lsu_sz_norm(input logic [2:0] s);
        return (s == LSU_SZ_B || s == LSU_SZ_H || s == LSU_SZ_BU || s == LSU_SZ_HU) ? s : LSU_SZ_W;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: selects the addressed lane of a read word and sign/zero-extends it to 32 bits
// Ports:
//   rdata - raw 32-bit word from memory
//   size  - func3 access size
//   a     - low address bits selecting the byte/halfword lane
//   rd    - formatted load result
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  size,
    input  logic [1:0]  a,
    output logic [31:0] rd
);

    logic [2:0]  n;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        n  = lsu_sz_norm(size);
        b  = rdata[{a, 3'b000} +: 8];
        h  = a[1] ? rdata[31:16] : rdata[15:0];
        rd = (n == LSU_SZ_B)  ? {{24{b[7]}}, b} :
             (n == LSU_SZ_BU) ? {24'h0, b} :
             (n == LSU_SZ_H)  ? {{16{h[15]}}, h} :
             (n == LSU_SZ_HU) ? {16'h0, h} : rdata;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences one load/store between the core and a handshaked data memory
// Ports:
//   clk_i, rst_ni                       - clock, synchronous active-low reset
//   core_req_i/we_i/size_i/addr_i/wd_i  - decoded memory instruction from the core
//   core_stall_o                        - holds PC/instruction while the access is in flight
//   core_rd_o, core_rd_valid_o          - formatted load data and its one-cycle writeback qualifier
//   mem_req_o/we_o/be_o/addr_o/wd_o     - memory request, held stable until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i - memory handshake and read data
//   misaligned_o                        - misaligned-access flag, only with LSU_MISALIGN_TRAP_EN
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic              core_stall_o,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_rd_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misaligned_o
`endif
);

    lsu_state_t        state_q, state_d;
    logic              we_q, mis_q, mis;
    logic [2:0]        size_q, n;
    logic [1:0]        a_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wd_q, rd_q, fmt_rd;

    assign n = lsu_sz_norm(core_size_i);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = ((n == LSU_SZ_H || n == LSU_SZ_HU) && core_addr_i[0]) ||
                 (n == LSU_SZ_W && core_addr_i[1:0] != 2'b00);
    assign misaligned_o = (state_q == DONE) && mis_q;
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = core_req_i ? (mis ? DONE : REQ) : IDLE;
            REQ:     state_d = mem_gnt_i ? (we_q ? DONE : WAIT) : REQ;
            WAIT:    state_d = mem_rvalid_i ? DONE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_stall_o    = (state_q == IDLE && core_req_i) || state_q == REQ || state_q == WAIT;
        mem_req_o       = state_q == REQ;
        core_rd_valid_o = state_q == DONE && !we_q && !mis_q;
    end

    // Request fields are latched once in IDLE so they stay stable across a withheld grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_q   <= 1'b0;
            mis_q  <= 1'b0;
            size_q <= 3'b000;
            a_q    <= 2'b00;
            be_q   <= 4'b0000;
            addr_q <= '0;
            wd_q   <= '0;
            rd_q   <= '0;
        end else begin
            if (state_q == IDLE && core_req_i) begin
                we_q   <= core_we_i;
                mis_q  <= mis;
                size_q <= core_size_i;
                a_q    <= core_addr_i[1:0];
                addr_q <= {core_addr_i[ADDR_W-1:2], 2'b00};
                be_q   <= !core_we_i ? 4'b1111 :
                          (n == LSU_SZ_B || n == LSU_SZ_BU) ? 4'b0001 << core_addr_i[1:0] :
                          (n == LSU_SZ_H || n == LSU_SZ_HU) ? (core_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                wd_q   <= (n == LSU_SZ_B || n == LSU_SZ_BU) ? {4{core_wd_i[7:0]}} :
                          (n == LSU_SZ_H || n == LSU_SZ_HU) ? {2{core_wd_i[15:0]}} : core_wd_i;
            end
            if (state_q == WAIT && mem_rvalid_i) rd_q <= fmt_rd;
        end
    end

    lsu_load_fmt u_fmt (
        .rdata (mem_rdata_i),
        .size  (size_q),
        .a     (a_q),
        .rd    (fmt_rd)
    );

    assign mem_we_o   = we_q;
    assign mem_be_o   = be_q;
    assign mem_addr_o = addr_q;
    assign mem_wd_o   = wd_q;
    assign core_rd_o  = rd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized transaction-level check of lsu_ctrl against a cycle-timeline model
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni, core_req_i, core_we_i, mem_gnt_i, mem_rvalid_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, mem_rdata_i;
    logic        core_stall_o, core_rd_valid_o, mem_req_o, mem_we_o;
    logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
    logic [3:0]  mem_be_o;
    logic        mis_o;

    always #5 clk_i = ~clk_i;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i),
        .core_stall_o(core_stall_o), .core_rd_o(core_rd_o), .core_rd_valid_o(core_rd_valid_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misaligned_o(mis_o)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign mis_o = 1'b0;
`endif

    int          n_vec = 0, n_err = 0, stall_cnt;
    logic        chk_en = 1'b0;
    logic        e_stall, e_req, e_rdv, e_we, e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, e_rd, model_rd;
    logic [3:0]  snap_be;
    logic [31:0] snap_wd, snap_addr;
    logic        snap_mis, snap_req;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            cmp("stall", 32'(core_stall_o), 32'(e_stall));
            cmp("mem_req", 32'(mem_req_o), 32'(e_req));
            cmp("rd_valid", 32'(core_rd_valid_o), 32'(e_rdv));
            cmp("rd", core_rd_o, e_rd);
            cmp("misaligned", 32'(mis_o), 32'(e_mis));
            if (e_req) begin
                cmp("mem_we", 32'(mem_we_o), 32'(e_we));
                cmp("mem_be", 32'(mem_be_o), 32'(e_be));
                cmp("mem_addr", mem_addr_o, e_addr);
                if (e_we) cmp("mem_wd", mem_wd_o, e_wd);
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] bs, hs;
        bs = d >> (8 * a);
        hs = d >> (16 * a[1]);
        case (sz)
            3'b000:  return {{24{bs[7]}}, bs[7:0]};
            3'b100:  return {24'h0, bs[7:0]};
            3'b001:  return {{16{hs[15]}}, hs[15:0]};
            3'b101:  return {16'h0, hs[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic we, input logic [2:0] sz, input logic [1:0] a);
        if (!we) return 4'b1111;
        case (sz)
            3'b000, 3'b100: return 4'b0001 << a;
            3'b001, 3'b101: return a[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'b000, 3'b100: return {4{wd[7:0]}};
            3'b001, 3'b101: return {2{wd[15:0]}};
            default:        return wd;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] sz, input logic [1:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        case (sz)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            default:        return a != 2'b00;
        endcase
`else
        return sz[0] & a[0] & 1'b0;
`endif
    endfunction

    task automatic tick();
        @(negedge clk_i);
        if (core_stall_o) stall_cnt++;
        if (mem_req_o) begin
            snap_req  = 1'b1;
            snap_be   = mem_be_o;
            snap_wd   = mem_wd_o;
            snap_addr = mem_addr_o;
        end
        if (mis_o) snap_mis = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_op(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int gw, input int rw);
        logic mis;
        mis = ref_mis(sz, addr[1:0]);
        stall_cnt = 0; snap_mis = 1'b0; snap_req = 1'b0;
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz; core_addr_i = addr; core_wd_i = wd;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        e_stall = 1'b1; e_req = 1'b0; e_rdv = 1'b0; e_mis = 1'b0; e_rd = model_rd;
        e_we = we; e_be = ref_be(we, sz, addr[1:0]); e_addr = {addr[31:2], 2'b00}; e_wd = ref_wd(sz, wd);
        tick();
        if (!mis) begin
            for (int i = 0; i <= gw; i++) begin
                mem_gnt_i    = (i == gw);
                mem_rvalid_i = (i != gw) && ($urandom_range(0, 1) == 1);
                mem_rdata_i  = $urandom;
                e_req = 1'b1;
                tick();
            end
            mem_gnt_i = 1'b0; e_req = 1'b0;
            if (!we) begin
                for (int j = 0; j <= rw; j++) begin
                    mem_rvalid_i = (j == rw);
                    mem_rdata_i  = (j == rw) ? rdata : $urandom;
                    tick();
                end
            end
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = ($urandom_range(0, 1) == 1); mem_rdata_i = $urandom;
        if (!we && !mis) model_rd = ref_load(sz, addr[1:0], rdata);
        e_stall = 1'b0; e_rdv = !we && !mis; e_rd = model_rd; e_mis = mis;
        tick();
        core_req_i = 1'b0; mem_rvalid_i = 1'b0;
        e_stall = 1'b0; e_req = 1'b0; e_rdv = 1'b0; e_mis = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'b000;
        core_addr_i = '0; core_wd_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        model_rd = '0;
        e_stall = 1'b0; e_req = 1'b0; e_rdv = 1'b0; e_mis = 1'b0; e_we = 1'b0;
        e_be = '0; e_addr = '0; e_wd = '0; e_rd = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        cmp("rst_stall", 32'(core_stall_o), 32'd0);
        cmp("rst_req", 32'(mem_req_o), 32'd0);
        cmp("rst_we", 32'(mem_we_o), 32'd0);
        cmp("rst_be", 32'(mem_be_o), 32'd0);
        cmp("rst_addr", mem_addr_o, 32'd0);
        cmp("rst_wd", mem_wd_o, 32'd0);
        cmp("rst_rd", core_rd_o, 32'd0);
        cmp("rst_rdv", 32'(core_rd_valid_o), 32'd0);
        cmp("rst_mis", 32'(mis_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        chk_en = 1'b1;

        do_op(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0);
        cmp("lw_rd", core_rd_o, 32'hDEAD_BEEF);
        cmp("lw_stalls", 32'(stall_cnt), 32'd3);
        cmp("lw_addr", snap_addr, 32'h0000_0010);
        cmp("lw_be", 32'(snap_be), 32'h0000_000F);

        do_op(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
        cmp("sb_be", 32'(snap_be), 32'h0000_0008);
        cmp("sb_wd", snap_wd, 32'hA5A5_A5A5);
        cmp("sb_stalls", 32'(stall_cnt), 32'd2);
        cmp("sb_rd_kept", core_rd_o, 32'hDEAD_BEEF);

        do_op(1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 0);
        cmp("lb_rd", core_rd_o, 32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h0080_0000, 0, 1);
        cmp("lbu_rd", core_rd_o, 32'h0000_0080);
        do_op(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 0);
        cmp("lh_rd", core_rd_o, 32'hFFFF_8001);

        do_op(1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 32'h0, 3, 0);
        cmp("gnt_wait_stalls", 32'(stall_cnt), 32'd5);
        cmp("gnt_wait_addr", snap_addr, 32'h0000_0020);

        do_op(1'b0, 3'b010, 32'h0000_0302, 32'h0, 32'hCAFE_F00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        cmp("mis_stalls", 32'(stall_cnt), 32'd1);
        cmp("mis_flag", 32'(snap_mis), 32'd1);
        cmp("mis_no_req", 32'(snap_req), 32'd0);
`else
        cmp("lw_unaligned_rd", core_rd_o, 32'hCAFE_F00D);
        cmp("lw_unaligned_addr", snap_addr, 32'h0000_0300);
`endif

        // Reset pulse while waiting for read data; the late rvalid must be dropped.
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h40;
        e_stall = 1'b1; e_req = 1'b0; e_rd = model_rd; e_we = 1'b0; e_be = 4'hF; e_addr = 32'h40;
        tick();
        mem_gnt_i = 1'b1; e_req = 1'b1;
        tick();
        mem_gnt_i = 1'b0; e_req = 1'b0; rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1; core_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        model_rd = '0; e_stall = 1'b0; e_rd = '0;
        tick();
        cmp("rst_mid_req", 32'(mem_req_o), 32'd0);
        cmp("rst_mid_addr", mem_addr_o, 32'd0);
        mem_rvalid_i = 1'b0;
        tick();

        for (int k = 0; k < 300; k++) begin
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) tick();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
